// File: rtl/mul4x4_sequencer.sv
`timescale 1ns/1ps
// mul4x4_sequencer
// Builds a WxW unsigned product from (W/4)^2 nibble products, one per cycle,
// using a single external combinational 4x4 multiplier (mul_a/mul_b -> mul_s).
// The product is returned on a valid/ready response channel.
// Optional build macro: MUL_ARB2_EN adds a second request port (req1_*) and a
// round-robin arbiter in front of the shared multiplier.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; operands latched and accumulator cleared on accept
// CALC  | one nibble partial product accumulated per cycle
// RESP  | product held on resp_p until resp_valid && resp_ready
module mul4x4_sequencer #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
`ifdef MUL_ARB2_EN
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
`endif
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [2*W-1:0]   resp_p,
  output logic             resp_id,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_s
);

  localparam int N  = W / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q;
  logic [2*W-1:0]     acc_q;
  logic [2*W-1:0]     pp_shifted;
  logic [2*W-1:0]     acc_sum;
  logic [IW-1:0]      i_q, j_q;
  logic [IW:0]        shamt_nib;
  logic               last_step;
  logic               idle;
  logic               accept;
  logic [W-1:0]       sel_a, sel_b;

  assign idle = (state_q == IDLE);

`ifdef MUL_ARB2_EN
  logic last_grant_q;
  logic grant0, grant1;
  logic resp_id_q;

  // Round-robin grant: on a tie (or with nobody asking) the port not granted
  // last time is favoured, so ready is always offered to exactly one port.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end else if (req_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end else begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end
  end

  assign req_ready  = idle & grant0;
  assign req1_ready = idle & grant1;
  assign accept     = (req_valid & req_ready) | (req1_valid & req1_ready);
  assign sel_a      = grant1 ? req1_a : req_a;
  assign sel_b      = grant1 ? req1_b : req_b;
  assign resp_id    = resp_id_q;

  // Remember the winner for fairness and tag the response with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      resp_id_q    <= 1'b0;
    end else if (accept) begin
      last_grant_q <= grant1;
      resp_id_q    <= grant1;
    end
  end
`else
  assign req_ready = idle;
  assign accept    = req_valid & req_ready;
  assign sel_a     = req_a;
  assign sel_b     = req_b;
  assign resp_id   = 1'b0;
`endif

  // Partial product for the current nibble pair, shifted to weight 16^(i+j).
  always_comb begin
    mul_a      = 4'd0;
    mul_b      = 4'd0;
    shamt_nib  = {1'b0, i_q} + {1'b0, j_q};
    pp_shifted = (2*W)'(mul_s) << {shamt_nib, 2'b00};
    if (state_q == CALC) begin
      mul_a = a_q[{i_q, 2'b00} +: 4];
      mul_b = b_q[{j_q, 2'b00} +: 4];
    end
  end

  assign acc_sum    = acc_q + pp_shifted;
  assign last_step  = (i_q == LAST_IDX) && (j_q == LAST_IDX);
  assign resp_valid = (state_q == RESP);

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (last_step) state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, accumulation, nibble indices and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      i_q    <= '0;
      j_q    <= '0;
      resp_p <= '0;
    end else begin
      if (idle && accept) begin
        a_q   <= sel_a;
        b_q   <= sel_b;
        acc_q <= '0;
        i_q   <= '0;
        j_q   <= '0;
      end else if (state_q == CALC) begin
        acc_q <= acc_sum;
        if (last_step) begin
          resp_p <= acc_sum;
          i_q    <= '0;
          j_q    <= '0;
        end else if (j_q == LAST_IDX) begin
          j_q <= '0;
          i_q <= i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul4x4_sequencer.sv
`timescale 1ns/1ps
// Directed self-checking bench for mul4x4_sequencer (W=8 plus a W=16 instance).
module tb_mul4x4_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_id;
  logic [7:0]  req_a, req_b, mul_s;
  logic [15:0] resp_p;
  logic [3:0]  mul_a, mul_b;

  logic        w_req_valid, w_req_ready, w_resp_valid, w_resp_ready, w_resp_id;
  logic [15:0] w_req_a, w_req_b;
  logic [31:0] w_resp_p;
  logic [3:0]  w_mul_a, w_mul_b;
  logic [7:0]  w_mul_s;

`ifdef MUL_ARB2_EN
  logic        req1_valid, req1_ready;
  logic [7:0]  req1_a, req1_b;
  logic        w_req1_ready;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  mul4x4_sequencer #(.W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
`ifdef MUL_ARB2_EN
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_p(resp_p), .resp_id(resp_id),
    .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s)
  );

  mul4x4_sequencer #(.W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_a(w_req_a), .req_b(w_req_b),
`ifdef MUL_ARB2_EN
    .req1_valid(1'b0), .req1_ready(w_req1_ready), .req1_a(16'h0), .req1_b(16'h0),
`endif
    .resp_valid(w_resp_valid), .resp_ready(w_resp_ready), .resp_p(w_resp_p), .resp_id(w_resp_id),
    .mul_a(w_mul_a), .mul_b(w_mul_b), .mul_s(w_mul_s)
  );

  // External 4x4 multipliers.
  assign mul_s   = {4'd0, mul_a} * {4'd0, mul_b};
  assign w_mul_s = {4'd0, w_mul_a} * {4'd0, w_mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for resp_valid, sampling 1ns after each rising edge.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Single port-0 transaction with resp_ready held high.
  task automatic txn0(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_p);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; resp_ready = 1'b1;
    chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_ready_calc"}, 32'(req_ready), 32'd0);
    chk({tag, "_mul_a0"}, 32'(mul_a), 32'(a[3:0]));
    chk({tag, "_mul_b0"}, 32'(mul_b), 32'(b[3:0]));
    wait_resp(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_p"}, 32'(resp_p), 32'(exp_p));
    chk({tag, "_id"}, 32'(resp_id), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid_after"}, 32'(resp_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    w_req_valid = 1'b0; w_req_a = '0; w_req_b = '0; w_resp_ready = 1'b1;
`ifdef MUL_ARB2_EN
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_p", 32'(resp_p), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    txn0("basic", 8'h12, 8'h34, 16'h03A8);
    txn0("ffxff", 8'hFF, 8'hFF, 16'hFE01);
    txn0("zero",  8'h00, 8'hA5, 16'h0000);
    txn0("one",   8'h01, 8'h80, 16'h0080);

    // Backpressure: product held, queued request waits.
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'h0A; req_b = 8'h0B; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'h03; req_b = 8'h03;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", 32'(resp_valid), 32'd1);
      chk("bp_p_held", 32'(resp_p), 32'h006E);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_handshake_valid", 32'(resp_valid), 32'd0);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    chk("bp_queued_latency", 32'(lat), 32'd4);
    chk("bp_queued_p", 32'(resp_p), 32'h0009);
    @(posedge clk); #1;

    // Reset in the 2nd CALC cycle.
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'h55; req_b = 8'h33;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(resp_valid), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_mul_a", 32'(mul_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_no_resp", 32'(resp_valid), 32'd0);
    txn0("after_rst", 8'h0F, 8'h10, 16'h00F0);

`ifdef MUL_ARB2_EN
    // Fresh reset so the last-grant register points at port 1.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    req_valid = 1'b1; req_a = 8'h02; req_b = 8'h03;
    req1_valid = 1'b1; req1_a = 8'h04; req1_b = 8'h05;
    #1;
    chk("arb_tie_ready0", 32'(req_ready), 32'd1);
    chk("arb_tie_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    chk("arb_first_latency", 32'(lat), 32'd4);
    chk("arb_first_p", 32'(resp_p), 32'h0006);
    chk("arb_first_id", 32'(resp_id), 32'd0);
    @(posedge clk); #1;
    wait_resp(lat);
    chk("arb_second_p", 32'(resp_p), 32'h0014);
    chk("arb_second_id", 32'(resp_id), 32'd1);
    req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("arb_idle_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      wait_resp(lat);
      chk("arb_rr_id", 32'(resp_id), 32'(k % 2));
      chk("arb_rr_p", 32'(resp_p), (k % 2 == 0) ? 32'h0006 : 32'h0014);
    end
    @(negedge clk);
    req_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
`endif

    // W=16 instance.
    @(negedge clk);
    w_req_valid = 1'b1; w_req_a = 16'hFFFF; w_req_b = 16'hFFFF;
    #1;
    chk("w16_ready", 32'(w_req_ready), 32'd1);
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    lat = 0;
    while (!w_resp_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16_latency", 32'(lat), 32'd16);
    chk("w16_p", w_resp_p, 32'hFFFE0001);
    chk("w16_id", 32'(w_resp_id), 32'd0);
    @(posedge clk); #1;
    chk("w16_done", 32'(w_resp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
